// File: rtl/pipe_stage_regs.sv
// rtl/pipe_stage_regs.sv - F/D, D/E, E/M, M/W pipeline latches with stall/flush control,
// event counters and a stall watchdog.
module pipe_stage_regs #(
  parameter int DW          = 16,
  parameter int CW          = 8,
  parameter int STALL_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] instr_in,
  input  logic [CW-1:0] ctl_in,
  input  logic [2:0]    dest_in,
  input  logic          if_stall,
  input  logic          FD_NOP,
  input  logic          DE_NOP,
  input  logic          EM_NOP,
  input  logic          MW_NOP,
  output logic          pc_hold,
  output logic          fd_valid,
  output logic [DW-1:0] fd_pc,
  output logic [DW-1:0] fd_instr,
  output logic          de_valid,
  output logic [CW-1:0] de_ctl,
  output logic [2:0]    de_dest,
  output logic          em_valid,
  output logic [CW-1:0] em_ctl,
  output logic [2:0]    em_dest,
  output logic          mw_valid,
  output logic [CW-1:0] mw_ctl,
  output logic [2:0]    mw_dest,
  output logic [1:0]    state,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   bubble_cnt,
  output logic          stall_err
);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_HOLD  = 2'b01,
    S_FLUSH = 2'b10
  } state_t;

  localparam int RW = $clog2(STALL_LIMIT + 1);

  state_t        cur_state;
  state_t        nxt_state;
  logic [RW-1:0] run_cnt;
  logic          flush;
  logic          de_squash;
  logic          any_squash;

  assign pc_hold    = if_stall & ~FD_NOP;
  assign flush      = FD_NOP & DE_NOP;
  assign de_squash  = DE_NOP | if_stall;
  assign any_squash = FD_NOP | de_squash | EM_NOP | MW_NOP;
  assign state      = cur_state;

  always_comb begin
    nxt_state = S_RUN;
    case (cur_state)
      // A flush lasts one cycle; only a repeated flush request extends it.
      S_FLUSH: nxt_state = flush ? S_FLUSH : S_RUN;
      default: begin
        if (flush)        nxt_state = S_FLUSH;
        else if (pc_hold) nxt_state = S_HOLD;
        else              nxt_state = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= S_RUN;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fd_valid <= 1'b0;
      fd_pc    <= '0;
      fd_instr <= '0;
      de_valid <= 1'b0;
      de_ctl   <= '0;
      de_dest  <= '0;
      em_valid <= 1'b0;
      em_ctl   <= '0;
      em_dest  <= '0;
      mw_valid <= 1'b0;
      mw_ctl   <= '0;
      mw_dest  <= '0;
    end else begin
      if (FD_NOP) begin
        fd_valid <= 1'b0;
        fd_pc    <= '0;
        fd_instr <= '0;
      end else if (!if_stall) begin
        fd_valid <= 1'b1;
        fd_pc    <= pc_in;
        fd_instr <= instr_in;
      end

      if (de_squash) begin
        de_valid <= 1'b0;
        de_ctl   <= '0;
        de_dest  <= '0;
      end else begin
        de_valid <= fd_valid;
        de_ctl   <= ctl_in;
        de_dest  <= dest_in;
      end

      if (EM_NOP) begin
        em_valid <= 1'b0;
        em_ctl   <= '0;
        em_dest  <= '0;
      end else begin
        em_valid <= de_valid;
        em_ctl   <= de_ctl;
        em_dest  <= de_dest;
      end

      if (MW_NOP) begin
        mw_valid <= 1'b0;
        mw_ctl   <= '0;
        mw_dest  <= '0;
      end else begin
        mw_valid <= em_valid;
        mw_ctl   <= em_ctl;
        mw_dest  <= em_dest;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      run_cnt    <= '0;
      stall_err  <= 1'b0;
    end else begin
      if (pc_hold && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (any_squash && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
      if (!if_stall)
        run_cnt <= '0;
      else if (run_cnt != RW'(STALL_LIMIT))
        run_cnt <= run_cnt + RW'(1);
      // Flag on the edge where the run length reaches the limit.
      if (if_stall && run_cnt == RW'(STALL_LIMIT - 1))
        stall_err <= 1'b1;
    end
  end

endmodule
